// File: rtl/operand_stack16b.sv
// rtl/operand_stack16b.sv - LIFO operand stack with registered TOS/NOS, full/empty status and sticky over/underflow flag
module operand_stack16b #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_THREE = CW'(3);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic             is_empty, is_full, err_set;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx, top_idx, below_idx;
  logic [WIDTH-1:0] wr_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  // Modular index math: count==DEPTH has zero low bits, so minus one lands on DEPTH-1.
  assign top_idx   = count_q[PTR_W-1:0] - PTR_W'(1);
  assign below_idx = count_q[PTR_W-1:0] - PTR_W'(3);

  always_comb begin
    count_d = count_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    err_set = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = count_q[PTR_W-1:0];
    wr_data = '0;
    case ({push, pop})
      2'b10: begin
        if (is_full) begin
          err_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = count_q[PTR_W-1:0];
          wr_data = din;
          count_d = count_q + CNT_ONE;
          tos_d   = din;
          nos_d   = tos_q;
        end
      end
      2'b01: begin
        if (is_empty) begin
          err_set = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
          tos_d   = nos_q;
          nos_d   = (count_q >= CNT_THREE) ? mem_q[below_idx] : '0;
        end
      end
      2'b11: begin
        // Replace on an empty stack degrades to a push but never flags an error.
        wr_en   = 1'b1;
        wr_data = din;
        tos_d   = din;
        if (is_empty) begin
          wr_idx  = '0;
          count_d = CNT_ONE;
          nos_d   = '0;
        end else begin
          wr_idx  = top_idx;
        end
      end
      default: begin
      end
    endcase
    if (err_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign tos   = tos_q;
  assign nos   = nos_q;
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign err   = err_q;

endmodule

// File: tb/tb_operand_stack16b.sv
// tb/tb_operand_stack16b.sv - directed self-checking bench for operand_stack16b
module tb_operand_stack16b;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] din = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] tos, nos;
  logic [3:0]  count;
  logic        empty, full, err;

  int total = 0;
  int bad = 0;

  operand_stack16b dut (
    .clk(clk), .reset(reset), .din(din), .push(push), .pop(pop), .clr_err(clr_err),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic op(input logic p, input logic q, input logic [15:0] d, input logic c);
    push = p; pop = q; din = d; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 16'hxxxx;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #100;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", empty, full); end
    total++; if (tos !== 16'd0 || nos !== 16'd0) begin bad++; $display("FAIL reset_tos_nos got tos=%0d nos=%0d exp 0 0", tos, nos); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
  endtask

  task automatic test_push_pop();
    op(1, 0, 16'd10, 0);
    op(1, 0, 16'd20, 0);
    op(1, 0, 16'd30, 0);
    total++; if (count !== 4'd3 || tos !== 16'd30 || nos !== 16'd20) begin bad++; $display("FAIL push3 got count=%0d tos=%0d nos=%0d exp 3 30 20", count, tos, nos); end
    op(0, 0, 16'hxxxx, 0);
    total++; if (count !== 4'd3 || tos !== 16'd30 || nos !== 16'd20) begin bad++; $display("FAIL hold_x got count=%0d tos=%0d nos=%0d exp 3 30 20", count, tos, nos); end
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd2 || tos !== 16'd20 || nos !== 16'd10) begin bad++; $display("FAIL pop1 got count=%0d tos=%0d nos=%0d exp 2 20 10", count, tos, nos); end
  endtask

  task automatic test_replace();
    op(1, 1, 16'd55, 0);
    total++; if (count !== 4'd2 || tos !== 16'd55 || nos !== 16'd10 || err !== 1'b0) begin bad++; $display("FAIL replace got count=%0d tos=%0d nos=%0d err=%0b exp 2 55 10 0", count, tos, nos, err); end
    op(1, 0, 16'd77, 0);
    op(1, 0, 16'd88, 0);
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd3 || tos !== 16'd77 || nos !== 16'd55) begin bad++; $display("FAIL replace_mem got count=%0d tos=%0d nos=%0d exp 3 77 55", count, tos, nos); end
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd2 || tos !== 16'd55 || nos !== 16'd10) begin bad++; $display("FAIL replace_deep got count=%0d tos=%0d nos=%0d exp 2 55 10", count, tos, nos); end
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd1 || tos !== 16'd10 || nos !== 16'd0) begin bad++; $display("FAIL pop_to1 got count=%0d tos=%0d nos=%0d exp 1 10 0", count, tos, nos); end
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd0 || tos !== 16'd0 || empty !== 1'b1) begin bad++; $display("FAIL pop_to0 got count=%0d tos=%0d empty=%0b exp 0 0 1", count, tos, empty); end
    op(1, 1, 16'd7, 0);
    total++; if (count !== 4'd1 || tos !== 16'd7 || nos !== 16'd0 || err !== 1'b0) begin bad++; $display("FAIL replace_empty got count=%0d tos=%0d nos=%0d err=%0b exp 1 7 0 0", count, tos, nos, err); end
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL drain got count=%0d err=%0b exp 0 0", count, err); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) op(1, 0, 16'(i), 0);
    total++; if (full !== 1'b1 || empty !== 1'b0 || count !== 4'd8) begin bad++; $display("FAIL full got full=%0b empty=%0b count=%0d exp 1 0 8", full, empty, count); end
    total++; if (tos !== 16'd8 || nos !== 16'd7 || err !== 1'b0) begin bad++; $display("FAIL full_top got tos=%0d nos=%0d err=%0b exp 8 7 0", tos, nos, err); end
    op(1, 0, 16'd99, 0);
    total++; if (tos !== 16'd8 || count !== 4'd8 || err !== 1'b1) begin bad++; $display("FAIL overflow got tos=%0d count=%0d err=%0b exp 8 8 1", tos, count, err); end
    op(1, 1, 16'd42, 0);
    total++; if (tos !== 16'd42 || nos !== 16'd7 || count !== 4'd8 || err !== 1'b1) begin bad++; $display("FAIL replace_full got tos=%0d nos=%0d count=%0d err=%0b exp 42 7 8 1", tos, nos, count, err); end
    op(0, 0, 16'hxxxx, 1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_err got=%0b exp=0", err); end
    op(0, 1, 16'hxxxx, 0);
    total++; if (tos !== 16'd7 || nos !== 16'd6 || count !== 4'd7 || full !== 1'b0) begin bad++; $display("FAIL pop_from_full got tos=%0d nos=%0d count=%0d full=%0b exp 7 6 7 0", tos, nos, count, full); end
    for (int i = 0; i < 6; i++) op(0, 1, 16'hxxxx, 0);
    total++; if (tos !== 16'd1 || nos !== 16'd0 || count !== 4'd1) begin bad++; $display("FAIL bottom_intact got tos=%0d nos=%0d count=%0d exp 1 0 1", tos, nos, count); end
    op(0, 1, 16'hxxxx, 0);
  endtask

  task automatic test_underflow();
    op(0, 1, 16'hxxxx, 0);
    total++; if (count !== 4'd0 || err !== 1'b1 || empty !== 1'b1 || tos !== 16'd0) begin bad++; $display("FAIL underflow got count=%0d err=%0b empty=%0b tos=%0d exp 0 1 1 0", count, err, empty, tos); end
    op(0, 1, 16'hxxxx, 1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL set_wins got=%0b exp=1", err); end
    op(0, 0, 16'hxxxx, 1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_after got=%0b exp=0", err); end
  endtask

  task automatic test_async_reset();
    op(1, 0, 16'd5, 0);
    op(1, 0, 16'd6, 0);
    total++; if (count !== 4'd2 || tos !== 16'd6 || nos !== 16'd5) begin bad++; $display("FAIL pre_reset got count=%0d tos=%0d nos=%0d exp 2 6 5", count, tos, nos); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (count !== 4'd0 || tos !== 16'd0 || nos !== 16'd0 || empty !== 1'b1) begin bad++; $display("FAIL async_reset got count=%0d tos=%0d nos=%0d empty=%0b exp 0 0 0 1", count, tos, nos, empty); end
    #3;
    reset = 1'b1;
    op(1, 0, 16'd9, 0);
    total++; if (count !== 4'd1 || tos !== 16'd9 || nos !== 16'd0 || err !== 1'b0) begin bad++; $display("FAIL post_reset_push got count=%0d tos=%0d nos=%0d err=%0b exp 1 9 0 0", count, tos, nos, err); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_replace();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
